// File: rtl/tt_capture_7in.sv
// ---------------------------------------------------------------------------
// tt_capture_7in
//   Sequential truth-table extractor. Walks the input vector x through
//   0 .. 2**NUM_INPUTS-1, holds each vector for SETTLE_CYCLES+1 cycles and
//   samples the attached function's output f_in on the last edge of the
//   hold window. The sampled bits are gathered in a shadow register and
//   published as truth_table_o / ones_count_o in a single FINISH cycle.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   start_i        capture request, honoured only in IDLE
//   abort_i        cancel a capture in progress (HOLD only)
//   x_o            vector driven to the function under test (x_o[0] = LSB)
//   f_in_i         function output for the current x_o
//   busy_o         capture in progress
//   done_o         one-cycle pulse marking a completed capture
//   tt_valid_o     truth_table_o / ones_count_o hold a complete result
//   truth_table_o  truth_table_o[i] = f(x = i)
//   ones_count_o   number of 1 bits in truth_table_o
// ---------------------------------------------------------------------------
module tt_capture_7in #(
    parameter int NUM_INPUTS    = 7,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic [NUM_INPUTS-1:0]      x_o,
    input  logic                       f_in_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       tt_valid_o,
    output logic [2**NUM_INPUTS-1:0]   truth_table_o,
    output logic [CNT_W-1:0]           ones_count_o
);

    localparam int TT_W = 2**NUM_INPUTS;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [3:0]            SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [NUM_INPUTS-1:0] X_LAST      = {NUM_INPUTS{1'b1}};

    logic [1:0]            state_q,    state_d;
    logic [NUM_INPUTS-1:0] x_q,        x_d;
    logic [3:0]            settle_q,   settle_d;
    logic [TT_W-1:0]       shadow_q,   shadow_d;
    logic [CNT_W-1:0]      run_cnt_q,  run_cnt_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  tt_valid_q, tt_valid_d;
    logic [TT_W-1:0]       tt_q,       tt_d;
    logic [CNT_W-1:0]      ones_q,     ones_d;

    logic                  sample_s;
    logic [TT_W-1:0]       shadow_wr_s;
    logic [CNT_W-1:0]      cnt_inc_s;

    // Sampling-edge helpers: shadow with the current bit merged in, and the
    // running count including the current sample. The shadow is cleared at
    // start, so OR-ing the new bit in is sufficient.
    always_comb begin
        sample_s    = (state_q == ST_HOLD) && (settle_q == SETTLE_LAST);
        shadow_wr_s = shadow_q | ({{(TT_W-1){1'b0}}, f_in_i} << x_q);
        cnt_inc_s   = run_cnt_q + {{(CNT_W-1){1'b0}}, f_in_i};
    end

    // Next-state logic for the IDLE / HOLD / FINISH capture sequence.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        settle_d   = settle_q;
        shadow_d   = shadow_q;
        run_cnt_d  = run_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tt_valid_d = tt_valid_q;
        tt_d       = tt_q;
        ones_d     = ones_q;

        case (state_q)
            ST_IDLE: begin
                // abort has no effect here, so start always wins
                if (start_i) begin
                    state_d    = ST_HOLD;
                    x_d        = {NUM_INPUTS{1'b0}};
                    settle_d   = 4'd0;
                    shadow_d   = {TT_W{1'b0}};
                    run_cnt_d  = {CNT_W{1'b0}};
                    busy_d     = 1'b1;
                    tt_valid_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (abort_i) begin
                    // published result is left untouched; tt_valid stays 0
                    state_d  = ST_IDLE;
                    x_d      = {NUM_INPUTS{1'b0}};
                    settle_d = 4'd0;
                    busy_d   = 1'b0;
                end else if (sample_s) begin
                    shadow_d  = shadow_wr_s;
                    run_cnt_d = cnt_inc_s;
                    settle_d  = 4'd0;
                    if (x_q == X_LAST) begin
                        // Result is registered on this edge so that the
                        // FINISH cycle already shows it together with done.
                        state_d    = ST_FINISH;
                        tt_d       = shadow_wr_s;
                        ones_d     = cnt_inc_s;
                        tt_valid_d = 1'b1;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        x_d        = {NUM_INPUTS{1'b0}};
                    end else begin
                        x_d = x_q + {{(NUM_INPUTS-1){1'b0}}, 1'b1};
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            ST_FINISH: begin
                // start is deliberately ignored in this cycle
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                x_d      = {NUM_INPUTS{1'b0}};
                settle_d = 4'd0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            x_q        <= {NUM_INPUTS{1'b0}};
            settle_q   <= 4'd0;
            shadow_q   <= {TT_W{1'b0}};
            run_cnt_q  <= {CNT_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_valid_q <= 1'b0;
            tt_q       <= {TT_W{1'b0}};
            ones_q     <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            settle_q   <= settle_d;
            shadow_q   <= shadow_d;
            run_cnt_q  <= run_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tt_valid_q <= tt_valid_d;
            tt_q       <= tt_d;
            ones_q     <= ones_d;
        end
    end

    assign x_o           = x_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign tt_valid_o    = tt_valid_q;
    assign truth_table_o = tt_q;
    assign ones_count_o  = ones_q;

endmodule

// File: tb/tb_tt_capture_7in.sv
module tb_tt_capture_7in;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   cnt;
        int           lat;
        int           t0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start0, abort0, start1, abort1;
    logic [6:0]   x0, x1;
    logic         f0, f1;
    logic         busy0, done0, tv0, busy1, done1, tv1;
    logic [127:0] tt0, tt1, rand_tt;
    logic [7:0]   cnt0, cnt1;
    int           fsel;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    tt_capture_7in dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .abort_i(abort0),
        .x_o(x0), .f_in_i(f0), .busy_o(busy0), .done_o(done0),
        .tt_valid_o(tv0), .truth_table_o(tt0), .ones_count_o(cnt0));

    tt_capture_7in #(.NUM_INPUTS(7), .SETTLE_CYCLES(3), .CNT_W(8)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .abort_i(abort1),
        .x_o(x1), .f_in_i(f1), .busy_o(busy1), .done_o(done1),
        .tt_valid_o(tv1), .truth_table_o(tt1), .ones_count_o(cnt1));

    // Function models attached to the DUTs
    function automatic logic maj3(logic [6:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    function automatic logic fmodel(int sel, logic [6:0] v);
        case (sel)
            0: return maj3(v);
            1: return v[6];
            2: return 1'b0;
            3: return 1'b1;
            4: return v[0];
            5: return ~v[0];
            default: return 1'b0;
        endcase
    endfunction

    assign f0 = (fsel == 6) ? rand_tt[x0] : fmodel(fsel, x0);

    // maj(x0,x1,x2) behind a 2-cycle register delay for the slow-settle DUT
    logic d1, d2;
    always @(posedge clk) begin
        d1 <= maj3(x1);
        d2 <= d1;
    end
    assign f1 = d2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor for the default DUT
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done0 === 1'b1) begin
            if (sb0.size() == 0) begin
                chk("unexpected_done0", 128'd1, 128'd0);
            end else begin
                e = sb0.pop_front();
                chk("tt0", tt0, e.tt);
                chk("cnt0", {120'd0, cnt0}, {120'd0, e.cnt});
                chk("tv0_at_done", {127'd0, tv0}, 128'd1);
                chk("busy0_at_done", {127'd0, busy0}, 128'd0);
                chk("x0_at_done", {121'd0, x0}, 128'd0);
                chk("lat0", 128'(cyc - e.t0), 128'(e.lat));
            end
        end
    end

    // Scoreboard monitor plus x-hold-period check for the SETTLE_CYCLES=3 DUT
    logic [6:0] last_x1;
    logic       busy1_prev = 1'b0;
    int         last_chg1  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (busy1 === 1'b1 && busy1_prev === 1'b0) begin
                last_chg1 = cyc;
            end else if (busy1 === 1'b1 && x1 !== last_x1) begin
                chk("x1_period", 128'(cyc - last_chg1), 128'd4);
                chk("x1_step", {121'd0, x1}, {121'd0, last_x1 + 7'd1});
                last_chg1 = cyc;
            end
            if (done1 === 1'b1) begin
                if (sb1.size() == 0) begin
                    chk("unexpected_done1", 128'd1, 128'd0);
                end else begin
                    e = sb1.pop_front();
                    chk("tt1", tt1, e.tt);
                    chk("cnt1", {120'd0, cnt1}, {120'd0, e.cnt});
                    chk("tv1_at_done", {127'd0, tv1}, 128'd1);
                    chk("lat1", 128'(cyc - e.t0), 128'(e.lat));
                end
            end
        end
        last_x1    = x1;
        busy1_prev = busy1;
    end

    task automatic wait_done0(int limit);
        int n = 0;
        while (done0 !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("done0_timeout", 128'd0, 128'd1);
        @(negedge clk);
    endtask

    task automatic pulse_start0();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    // One capture on the default DUT; optional stray starts while busy and
    // an abort raised together with start (abort must be ignored in IDLE).
    task automatic capture(int sel, logic [127:0] tt, logic [7:0] cnt,
                           bit strays, bit abort_too);
        exp_t e;
        fsel = sel;
        @(negedge clk);
        start0 = 1'b1;
        abort0 = abort_too;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        abort0 = 1'b0;
        e.tt = tt; e.cnt = cnt; e.lat = 256; e.t0 = cyc;
        sb0.push_back(e);
        if (strays) begin
            repeat (10) @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                start0 = 1'b1;
                @(negedge clk);
                start0 = 1'b0;
                repeat (40 + $urandom_range(0, 20)) @(negedge clk);
            end
        end
        wait_done0(400);
        chk("tv0_after", {127'd0, tv0}, 128'd1);
    endtask

    initial begin
        exp_t e;
        logic [127:0] aa;
        rst = 1'b1; start0 = 1'b0; abort0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; fsel = 0; rand_tt = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {127'd0, busy0}, 128'd0);
        chk("rst_done", {127'd0, done0}, 128'd0);
        chk("rst_tv", {127'd0, tv0}, 128'd0);
        chk("rst_x", {121'd0, x0}, 128'd0);
        chk("rst_tt", tt0, 128'd0);
        chk("rst_cnt", {120'd0, cnt0}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Slow-settle DUT: delayed majority, 512-cycle latency
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        e.tt = {16{8'hE8}}; e.cnt = 8'd64; e.lat = 512; e.t0 = cyc;
        sb1.push_back(e);
        begin
            int n = 0;
            while (done1 !== 1'b1 && n < 700) begin
                @(negedge clk);
                n++;
            end
            if (n >= 700) chk("done1_timeout", 128'd0, 128'd1);
            @(negedge clk);
        end

        // Directed captures on the default DUT
        capture(0, {16{8'hE8}}, 8'd64, 1'b0, 1'b0);
        capture(1, {{64{1'b1}}, {64{1'b0}}}, 8'd64, 1'b0, 1'b1);
        capture(2, 128'd0, 8'd0, 1'b0, 1'b0);
        capture(3, {128{1'b1}}, 8'd128, 1'b0, 1'b0);
        aa = {64{2'b10}};
        capture(4, aa, 8'd64, 1'b0, 1'b0);

        // Abort at cycle 100 of an f=~x0 capture
        fsel = 5;
        pulse_start0();
        repeat (99) @(negedge clk);
        abort0 = 1'b1;
        @(posedge clk);
        #1 abort0 = 1'b0;
        chk("abort_busy", {127'd0, busy0}, 128'd0);
        chk("abort_tv", {127'd0, tv0}, 128'd0);
        chk("abort_x", {121'd0, x0}, 128'd0);
        chk("abort_tt", tt0, aa);
        chk("abort_cnt", {120'd0, cnt0}, 128'd64);
        repeat (300) @(negedge clk);
        chk("abort_tv_later", {127'd0, tv0}, 128'd0);
        capture(5, {64{2'b01}}, 8'd64, 1'b0, 1'b0);

        // Randomised tables, some with stray starts while busy
        for (int r = 0; r < 4; r++) begin
            rand_tt = {$urandom, $urandom, $urandom, $urandom};
            capture(6, rand_tt, 8'($countones(rand_tt)), r[0], 1'b0);
        end

        // Reset at cycle 50 of a capture, then a normal capture
        rand_tt = {$urandom, $urandom, $urandom, $urandom};
        fsel = 6;
        pulse_start0();
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", {127'd0, busy0}, 128'd0);
        chk("mid_rst_done", {127'd0, done0}, 128'd0);
        chk("mid_rst_tv", {127'd0, tv0}, 128'd0);
        chk("mid_rst_x", {121'd0, x0}, 128'd0);
        chk("mid_rst_tt", tt0, 128'd0);
        chk("mid_rst_cnt", {120'd0, cnt0}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        capture(6, rand_tt, 8'($countones(rand_tt)), 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb0_drained", 128'(sb0.size()), 128'd0);
        chk("sb1_drained", 128'(sb1.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
